// File: rtl/unpool_pkg.sv
// Shared encodings for the 2x2 nearest-neighbour unpooling scheduler:
// quadrant selects, FSM states and a ceil-log2 helper for counter widths.
package unpool_pkg;

  typedef enum logic [2:0] {
    S_IN = 3'd0,
    S_UL = 3'd1,
    S_UR = 3'd2,
    S_LL = 3'd3,
    S_LR = 3'd4
  } state_e;

  localparam logic [1:0] QUAD_UL = 2'b00;
  localparam logic [1:0] QUAD_UR = 2'b01;
  localparam logic [1:0] QUAD_LL = 2'b10;
  localparam logic [1:0] QUAD_LR = 2'b11;

  // Floored at 1 so a single-row frame still gets a usable counter.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 1; i < value; i = i * 2) r = r + 1;
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/unpool_scheduler.sv
// Sequences 2x2 nearest-neighbour unpooling: upper-row beats follow each input
// pixel, then the stored row is replayed from the line buffer for the lower row.
module unpool_scheduler
  import unpool_pkg::*;
#(
  parameter int IN_W     = 320,
  parameter int IN_H     = 240,
  parameter int IN_HBITW = clog2(IN_W),
  parameter int IN_VBITW = clog2(IN_H)
) (
  input  logic                clock,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IN_HBITW-1:0] in_hcnt,
  input  logic [IN_VBITW-1:0] in_vcnt,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [1:0]          out_sel,
  output logic [IN_HBITW:0]   out_hcnt,
  output logic [IN_VBITW:0]   out_vcnt,
  output logic                buf_we,
  output logic [IN_HBITW-1:0] buf_waddr,
  output logic [IN_HBITW-1:0] buf_raddr,
  output logic                frame_done,
  output logic                sync_err,
  output state_e              dbg_state
);

  // Both streams are valid/ready: a beat transfers on the rising edge where
  // valid && ready; valid and payload hold stable until then. in_ready is the
  // only combinational output and depends on state alone (high in S_IN).

  localparam logic [IN_HBITW-1:0] H_LAST = IN_HBITW'(IN_W - 1);
  localparam logic [IN_VBITW-1:0] V_LAST = IN_VBITW'(IN_H - 1);

  state_e                state_q, state_d;
  logic [IN_HBITW-1:0]   h_q, h_d;
  logic [IN_VBITW-1:0]   v_q, v_d;
  logic [1:0]            sel_q, sel_d;
  logic                  valid_q, valid_d;
  logic [IN_HBITW:0]     hcnt_q, hcnt_d;
  logic [IN_VBITW:0]     vcnt_q, vcnt_d;
  logic                  we_q, we_d;
  logic [IN_HBITW-1:0]   waddr_q, waddr_d;
  logic [IN_HBITW-1:0]   raddr_q, raddr_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    waddr_d = waddr_q;
    raddr_d = raddr_q;
    err_d   = err_q;
    we_d    = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      S_IN: begin
        if (in_valid) begin
          we_d    = 1'b1;
          waddr_d = h_q;
          state_d = S_UL;
          valid_d = 1'b1;
          sel_d   = QUAD_UL;
          // Tags are only checked; the internal counters stay authoritative.
          if (in_hcnt != h_q || in_vcnt != v_q) err_d = 1'b1;
        end
      end
      S_UL: begin
        if (out_ready) begin
          state_d = S_UR;
          sel_d   = QUAD_UR;
        end
      end
      S_UR: begin
        if (out_ready) begin
          if (h_q == H_LAST) begin
            h_d     = '0;
            raddr_d = '0;
            state_d = S_LL;
            sel_d   = QUAD_LL;
          end else begin
            h_d     = h_q + 1'b1;
            state_d = S_IN;
            valid_d = 1'b0;
          end
        end
      end
      S_LL: begin
        if (out_ready) begin
          state_d = S_LR;
          sel_d   = QUAD_LR;
        end
      end
      S_LR: begin
        if (out_ready) begin
          if (h_q != H_LAST) begin
            h_d     = h_q + 1'b1;
            raddr_d = h_q + 1'b1;
            state_d = S_LL;
            sel_d   = QUAD_LL;
          end else begin
            h_d     = '0;
            valid_d = 1'b0;
            state_d = S_IN;
            if (v_q == V_LAST) begin
              v_d    = '0;
              done_d = 1'b1;
            end else begin
              v_d = v_q + 1'b1;
            end
          end
        end
      end
      default: state_d = S_IN;
    endcase

    hcnt_d = {h_d, sel_d[0]};
    vcnt_d = {v_d, sel_d[1]};
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q <= S_IN;
      h_q     <= '0;
      v_q     <= '0;
      sel_q   <= QUAD_UL;
      valid_q <= 1'b0;
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      raddr_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      raddr_q <= raddr_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign in_ready   = (state_q == S_IN);
  assign out_valid  = valid_q;
  assign out_sel    = sel_q;
  assign out_hcnt   = hcnt_q;
  assign out_vcnt   = vcnt_q;
  assign buf_we     = we_q;
  assign buf_waddr  = waddr_q;
  assign buf_raddr  = raddr_q;
  assign frame_done = done_q;
  assign sync_err   = err_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_unpool_scheduler.sv
// Scoreboard bench for unpool_scheduler on a 4x2 frame: a pixel-level model
// queues the expected beats and write addresses, a monitor pops and compares.
module tb_unpool_scheduler;
  import unpool_pkg::*;

  localparam int IN_W     = 4;
  localparam int IN_H     = 2;
  localparam int HW       = 2;
  localparam int VW       = 1;
  localparam int HCW      = HW + 1;
  localparam int VCW      = VW + 1;
  localparam int CLK_HALF = 5;

  logic           clock, rst;
  logic           in_valid, in_ready, out_valid, out_ready;
  logic [HW-1:0]  in_hcnt, buf_waddr, buf_raddr;
  logic [VW-1:0]  in_vcnt;
  logic [1:0]     out_sel;
  logic [HCW-1:0] out_hcnt;
  logic [VCW-1:0] out_vcnt;
  logic           buf_we, frame_done, sync_err;
  state_e         dbg_state;

  typedef struct packed {
    logic           chk_raddr;
    logic           last;
    logic [HW-1:0]  raddr;
    logic [1:0]     sel;
    logic [HCW-1:0] hcnt;
    logic [VCW-1:0] vcnt;
  } exp_t;
  localparam int EW = $bits(exp_t);

  logic [EW-1:0] exp_q[$];
  logic [HW-1:0] waddr_q[$];

  int n_checks   = 0;
  int n_fail     = 0;
  int n_beats    = 0;
  int k_model    = 0;
  int ready_mode = 0;
  bit exp_err    = 1'b0;
  bit done_pending = 1'b0;
  bit stall_req  = 1'b0;
  bit stall_done = 1'b0;

  unpool_scheduler #(
    .IN_W(IN_W), .IN_H(IN_H), .IN_HBITW(HW), .IN_VBITW(VW)
  ) dut (
    .clock(clock), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_hcnt(in_hcnt), .in_vcnt(in_vcnt),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sel(out_sel), .out_hcnt(out_hcnt), .out_vcnt(out_vcnt),
    .buf_we(buf_we), .buf_waddr(buf_waddr), .buf_raddr(buf_raddr),
    .frame_done(frame_done), .sync_err(sync_err), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clock = 1'b0;
    forever #CLK_HALF clock = ~clock;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Input pixel k of a frame sits at (k % W, k / W); each one yields UL/UR
  // beats, and the row's last pixel triggers the full lower-row replay.
  task automatic model_accept();
    int h, v;
    exp_t e;
    h = k_model % IN_W;
    v = k_model / IN_W;
    waddr_q.push_back(HW'(h));
    if (int'(in_hcnt) != h || int'(in_vcnt) != v) exp_err = 1'b1;
    e = '0;
    e.sel = QUAD_UL; e.hcnt = HCW'(2 * h);     e.vcnt = VCW'(2 * v);
    exp_q.push_back(e);
    e.sel = QUAD_UR; e.hcnt = HCW'(2 * h + 1);
    exp_q.push_back(e);
    if (h == IN_W - 1) begin
      for (int x = 0; x < IN_W; x++) begin
        e = '0;
        e.chk_raddr = 1'b1;
        e.raddr     = HW'(x);
        e.vcnt      = VCW'(2 * v + 1);
        e.sel = QUAD_LL; e.hcnt = HCW'(2 * x);
        exp_q.push_back(e);
        e.sel = QUAD_LR; e.hcnt = HCW'(2 * x + 1);
        e.last = (x == IN_W - 1) && (v == IN_H - 1);
        exp_q.push_back(e);
      end
    end
    k_model = (k_model + 1) % (IN_W * IN_H);
  endtask

  always @(negedge clock) begin
    #1;
    if (rst) begin
      exp_q.delete();
      waddr_q.delete();
      k_model = 0;
      exp_err = 1'b0;
    end else if (in_valid && in_ready) begin
      model_accept();
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clock) begin : monitor
    exp_t e;
    if (rst) begin
      done_pending = 1'b0;
    end else begin
      check("out_valid", out_valid, exp_q.size() != 0);
      check("in_ready", in_ready, exp_q.size() == 0);
      check("buf_we", buf_we, waddr_q.size() != 0);
      if (buf_we && waddr_q.size() != 0) begin
        check("buf_waddr", buf_waddr, waddr_q[0]);
        void'(waddr_q.pop_front());
      end
      if (frame_done || done_pending) check("frame_done", frame_done, done_pending);
      done_pending = 1'b0;
      check("sync_err", sync_err, exp_err);
      if (out_valid && exp_q.size() != 0) begin
        e = exp_t'(exp_q[0]);
        check("out_sel", out_sel, e.sel);
        check("out_hcnt", out_hcnt, e.hcnt);
        check("out_vcnt", out_vcnt, e.vcnt);
        if (e.chk_raddr) check("buf_raddr", buf_raddr, e.raddr);
        if (out_ready) begin
          void'(exp_q.pop_front());
          n_beats++;
          done_pending = e.last;
        end
      end
    end
  end

  // ---------------- drivers ----------------
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clock); #1;
      if (stall_req && out_valid && out_sel == QUAD_UR &&
          out_hcnt == HCW'(5) && out_vcnt == VCW'(0)) begin
        stall_req = 1'b0;
        out_ready = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        out_ready  = 1'b1;
        stall_done = 1'b1;
      end else if (ready_mode == 1) begin
        out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send_pixel(input int tag_h, input int v, input int gap);
    bit got;
    in_valid = 1'b0;
    repeat (gap) begin @(posedge clock); #1; end
    in_hcnt  = HW'(tag_h);
    in_vcnt  = VW'(v);
    in_valid = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 400 && !got; c++) begin
      @(negedge clock);
      got = in_ready;
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
    check("accept_in_time", got, 1'b1);
  endtask

  // gap_mode < 0 picks a random 0..3 cycle gap per pixel.
  task automatic send_frame(input int gap_mode, input bit err_en);
    for (int v = 0; v < IN_H; v++) begin
      for (int h = 0; h < IN_W; h++) begin
        int gap, tag;
        gap = (gap_mode < 0) ? int'($urandom_range(0, 3)) : gap_mode;
        tag = (err_en && v == 0 && h == 1) ? 3 : h;
        send_pixel(tag, v, gap);
      end
    end
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    while ((exp_q.size() != 0 || waddr_q.size() != 0 || done_pending) && c < 500) begin
      @(posedge clock); #1;
      c++;
    end
    check("drain_in_time", c < 500, 1'b1);
    repeat (2) begin @(posedge clock); #1; end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_out_valid"}, out_valid, 1'b0);
    check({tag, "_out_sel"}, out_sel, 2'b00);
    check({tag, "_out_hcnt"}, out_hcnt, '0);
    check({tag, "_out_vcnt"}, out_vcnt, '0);
    check({tag, "_buf_we"}, buf_we, 1'b0);
    check({tag, "_buf_waddr"}, buf_waddr, '0);
    check({tag, "_buf_raddr"}, buf_raddr, '0);
    check({tag, "_frame_done"}, frame_done, 1'b0);
    check({tag, "_sync_err"}, sync_err, 1'b0);
    check({tag, "_in_ready"}, in_ready, 1'b1);
    check({tag, "_state"}, dbg_state, S_IN);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit reached;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_hcnt  = '0;
    in_vcnt  = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_reset("por");
    @(posedge clock); #1;
    rst = 1'b0;

    // Back-to-back pixels, no backpressure: 32 beats, one frame_done.
    n_beats = 0;
    send_frame(0, 1'b0);
    wait_idle();
    check("frame1_beats", n_beats, 32);

    // Five-cycle stall on the UR beat of pixel h=2.
    stall_req = 1'b1;
    send_frame(0, 1'b0);
    wait_idle();
    check("stall_applied", stall_done, 1'b1);

    // Three-cycle input gaps between every pixel.
    send_frame(3, 1'b0);
    wait_idle();

    // Random gaps and random output backpressure over several frames.
    ready_mode = 1;
    repeat (3) send_frame(-1, 1'b0);
    wait_idle();
    ready_mode = 0;

    // Wrong column tag on pixel h=1: sync_err must rise and stick.
    send_frame(0, 1'b1);
    wait_idle();
    check("sync_err_sticky", sync_err, 1'b1);

    // Reset during the lower-row replay of row 0.
    for (int h = 0; h < IN_W; h++) send_pixel(h, 0, 0);
    reached = 1'b0;
    for (int c = 0; c < 50 && !reached; c++) begin
      if (out_valid && out_sel == QUAD_LL) reached = 1'b1;
      else begin @(posedge clock); #1; end
    end
    check("reached_ll", reached, 1'b1);
    rst = 1'b1;
    @(negedge clock);
    check_reset("mid_replay");
    repeat (2) begin @(posedge clock); #1; end
    rst = 1'b0;
    send_frame(0, 1'b0);
    wait_idle();

    check("exp_q_drained", exp_q.size(), 0);
    check("waddr_q_drained", waddr_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
